ifmap_fetch: RTL and testbench

//  Upstream of the input-buffer sender. Fetches one ifmap tile from external memory as row bursts.

---
 rtl/ib_pkg.sv | 31 +++
 rtl/ifmap_addr_gen.sv | 60 ++++++
 rtl/ifmap_fetch.sv | 176 +++++++++++++++++
 tb/tb_ifmap_fetch.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ib_pkg.sv
// Shared types and sizing helpers for the ifmap fetch path.
// Default geometry matches the input-buffer sender it feeds.
package ib_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_DATA,
    S_GAP,
    S_FIN
  } fetch_state_e;

  function automatic int calc_rows(input int poy, input int stride, input int ksize);
    return (poy - 1) * stride + ksize;
  endfunction

  // Counter width able to hold 0..n-1.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int DEF_DW     = 32;
  localparam int DEF_AW     = 32;
  localparam int DEF_BURST  = 32;
  localparam int DEF_POY    = 4;
  localparam int DEF_STRIDE = 2;
  localparam int DEF_KSIZE  = 3;
  localparam int DEF_GAP    = 9;
  localparam int DEF_ROWS   = calc_rows(DEF_POY, DEF_STRIDE, DEF_KSIZE);

endpackage

// File: rtl/ifmap_addr_gen.sv
// Row/channel walker: addr is the current burst start; step advances one row, wrapping
// into the next channel. load restarts at base. Updates one cycle after load/step.
module ifmap_addr_gen
  import ib_pkg::*;
#(
  parameter int AW   = DEF_AW,
  parameter int ROWS = DEF_ROWS
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic          step,
  input  logic [AW-1:0] base_addr,
  input  logic [AW-1:0] row_pitch,
  input  logic [AW-1:0] chan_pitch,
  input  logic [15:0]   nchan,
  output logic [AW-1:0] addr,
  output logic          last_row,
  output logic          last_chan
);

  localparam int RW = cnt_w(ROWS);
  localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);

  logic [AW-1:0] addr_q;
  logic [AW-1:0] chan_base_q;
  logic [RW-1:0] row_q;
  logic [15:0]   ch_q;

  // chan_base_q holds the row-0 address of the current channel, so a channel
  // wrap rewinds the row term without a multiply.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q      <= '0;
      chan_base_q <= '0;
      row_q       <= '0;
      ch_q        <= '0;
    end else if (load) begin
      addr_q      <= base_addr;
      chan_base_q <= base_addr;
      row_q       <= '0;
      ch_q        <= '0;
    end else if (step) begin
      if (row_q == ROW_LAST) begin
        row_q       <= '0;
        ch_q        <= ch_q + 16'd1;
        chan_base_q <= chan_base_q + chan_pitch;
        addr_q      <= chan_base_q + chan_pitch;
      end else begin
        row_q  <= row_q + RW'(1);
        addr_q <= addr_q + row_pitch;
      end
    end
  end

  assign addr      = addr_q;
  assign last_row  = (row_q == ROW_LAST);
  assign last_chan = (ch_q == nchan - 16'd1);

endmodule

// File: rtl/ifmap_fetch.sv
// Fetches an ifmap tile as one BURST-beat read per row per channel, single outstanding.
// Beats forwarded one cycle after acceptance; source stalls pass through; GAP idle cycles between bursts.
module ifmap_fetch
  import ib_pkg::*;
#(
  parameter int DW     = DEF_DW,
  parameter int AW     = DEF_AW,
  parameter int BURST  = DEF_BURST,
  parameter int POY    = DEF_POY,
  parameter int STRIDE = DEF_STRIDE,
  parameter int KSIZE  = DEF_KSIZE,
  parameter int GAP    = DEF_GAP
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic [AW-1:0] row_pitch,
  input  logic [AW-1:0] chan_pitch,
  input  logic [15:0]   nchan,
  output logic          mem_arvalid,
  input  logic          mem_arready,
  output logic [AW-1:0] mem_araddr,
  output logic [7:0]    mem_arlen,
  input  logic          mem_rvalid,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_rlast,
  output logic          mem_rready,
  output logic          data_load,
  output logic          rvalid,
  output logic [DW-1:0] rdata,
  output logic          busy,
  output logic          done,
  output logic          err
);

  localparam int ROWS = calc_rows(POY, STRIDE, KSIZE);
  localparam int BCW  = cnt_w(BURST);
  localparam int GCW  = cnt_w(GAP + 1);
  localparam logic [BCW-1:0] BEAT_LAST = BCW'(BURST - 1);
  localparam logic [GCW-1:0] GAP_END   = GCW'(GAP);

  fetch_state_e  state_q;
  logic [AW-1:0] row_pitch_q;
  logic [AW-1:0] chan_pitch_q;
  logic [15:0]   nchan_q;
  logic [BCW-1:0] beat_q;
  logic [GCW-1:0] gap_q;
  logic          arvalid_q;
  logic          rready_q;
  logic          rvalid_q;
  logic [DW-1:0] rdata_q;
  logic          data_load_q;
  logic          done_q;
  logic          err_q;

  logic          start_ok;
  logic          beat_ok;
  logic          gap_end;
  logic          last_row;
  logic          last_chan;

  assign start_ok = start && (state_q == S_IDLE);
  assign beat_ok  = mem_rvalid && rready_q;
  assign gap_end  = (state_q == S_GAP) && (gap_q == GAP_END);

  ifmap_addr_gen #(
    .AW   (AW),
    .ROWS (ROWS)
  ) u_addr_gen (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (start_ok),
    .step       (gap_end),
    .base_addr  (base_addr),
    .row_pitch  (row_pitch_q),
    .chan_pitch (chan_pitch_q),
    .nchan      (nchan_q),
    .addr       (mem_araddr),
    .last_row   (last_row),
    .last_chan  (last_chan)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      row_pitch_q  <= '0;
      chan_pitch_q <= '0;
      nchan_q      <= '0;
      beat_q       <= '0;
      gap_q        <= '0;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      rvalid_q     <= 1'b0;
      rdata_q      <= '0;
      data_load_q  <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      done_q   <= 1'b0;
      rvalid_q <= beat_ok;
      if (beat_ok) begin
        rdata_q <= mem_rdata;
        if (mem_rlast != (beat_q == BEAT_LAST)) err_q <= 1'b1;
      end

      case (state_q)
        S_IDLE: begin
          if (start) begin
            err_q        <= 1'b0;
            data_load_q  <= 1'b1;
            row_pitch_q  <= row_pitch;
            chan_pitch_q <= chan_pitch;
            nchan_q      <= nchan;
            if (nchan == 16'd0) begin
              state_q <= S_FIN;
            end else begin
              state_q   <= S_REQ;
              arvalid_q <= 1'b1;
            end
          end
        end
        S_REQ: begin
          if (mem_arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            beat_q    <= '0;
            state_q   <= S_DATA;
          end
        end
        // Burst end is decided by the beat count; rlast only feeds err.
        S_DATA: begin
          if (beat_ok) begin
            if (beat_q == BEAT_LAST) begin
              rready_q <= 1'b0;
              gap_q    <= '0;
              state_q  <= S_GAP;
            end else begin
              beat_q <= beat_q + BCW'(1);
            end
          end
        end
        // First GAP cycle carries the last forwarded beat, so count to GAP inclusive.
        S_GAP: begin
          if (gap_q == GAP_END) begin
            if (last_row && last_chan) begin
              state_q <= S_FIN;
            end else begin
              state_q   <= S_REQ;
              arvalid_q <= 1'b1;
            end
          end else begin
            gap_q <= gap_q + GCW'(1);
          end
        end
        S_FIN: begin
          done_q      <= 1'b1;
          data_load_q <= 1'b0;
          state_q     <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign mem_arvalid = arvalid_q;
  assign mem_arlen   = 8'(BURST - 1);
  assign mem_rready  = rready_q;
  assign data_load   = data_load_q;
  assign rvalid      = rvalid_q;
  assign rdata       = rdata_q;
  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;
  assign err         = err_q;

endmodule

// File: tb/tb_ifmap_fetch.sv
// Bench for ifmap_fetch: memory responder, stream monitor, table and random jobs vs a request/beat list model.
module tb_ifmap_fetch;

  localparam int BURST = 32;
  localparam int ROWS  = 9;
  localparam int GAP   = 9;

  typedef struct {
    int          nchan;
    logic [31:0] base;
    logic [31:0] rp;
    logic [31:0] cp;
    int          ard;
    int          stall;
    int          bad;
    int          poke;
    int          exp_reqs;
    int          chk_idx;
    logic [31:0] chk_addr;
    logic        exp_err;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [31:0] base_addr, row_pitch, chan_pitch;
  logic [15:0] nchan;
  logic        mem_arvalid, mem_arready;
  logic [31:0] mem_araddr;
  logic [7:0]  mem_arlen;
  logic        mem_rvalid, mem_rlast, mem_rready;
  logic [31:0] mem_rdata;
  logic        data_load, rvalid, busy, done, err;
  logic [31:0] rdata;

  int n_chk = 0;
  int n_pass = 0;

  int job_id = 0;
  int r_ard = 0;
  int r_stall = 0;
  int r_bad = -1;

  logic [31:0] obs_addr[$];
  logic [31:0] obs_beat[$];
  int done_cnt = 0;
  int gap_viol = 0;
  int dl_viol = 0;
  int ar_unstable = 0;

  ifmap_fetch dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .base_addr  (base_addr),
    .row_pitch  (row_pitch),
    .chan_pitch (chan_pitch),
    .nchan      (nchan),
    .mem_arvalid(mem_arvalid),
    .mem_arready(mem_arready),
    .mem_araddr (mem_araddr),
    .mem_arlen  (mem_arlen),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .mem_rlast  (mem_rlast),
    .mem_rready (mem_rready),
    .data_load  (data_load),
    .rvalid     (rvalid),
    .rdata      (rdata),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] beat_data(input logic [31:0] a, input int b);
    return a ^ (32'(b) * 32'h0100_0193) ^ 32'h5A5A_0000;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  // Memory responder: holds a beat until accepted, random source stalls.
  initial begin
    int ar_wait, beat, jid, nreq;
    logic act, flush, s_arhs, s_arv, s_rhs;
    logic [31:0] caddr, s_addr;
    mem_arready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0; mem_rlast = 1'b0;
    ar_wait = 0; beat = 0; jid = 0; nreq = 0; act = 1'b0; flush = 1'b1; caddr = '0;
    forever begin
      @(negedge clk);
      s_arhs = mem_arvalid && mem_arready;
      s_arv  = mem_arvalid;
      s_addr = mem_araddr;
      s_rhs  = mem_rvalid && mem_rready;
      @(posedge clk);
      #1;
      if (jid != job_id) begin jid = job_id; nreq = 0; end
      if (!rst_n) begin
        flush = 1'b1;
      end else begin
        if (flush) begin
          flush = 1'b0; act = 1'b0; mem_rvalid = 1'b0; mem_rlast = 1'b0; ar_wait = 0;
          s_rhs = 1'b0; s_arhs = 1'b0;
        end
        if (s_rhs) begin
          beat++;
          if (beat == BURST) act = 1'b0;
        end
        if (s_arhs) begin act = 1'b1; caddr = s_addr; beat = 0; nreq++; end
        if (r_ard == 0) mem_arready = 1'b1;
        else if (s_arv && !s_arhs && !act) begin
          if (ar_wait >= r_ard) mem_arready = 1'b1;
          else begin ar_wait++; mem_arready = 1'b0; end
        end else begin
          mem_arready = 1'b0; ar_wait = 0;
        end
        if (act && (!mem_rvalid || s_rhs)) begin
          if ($urandom_range(0, 99) >= r_stall) begin
            mem_rvalid = 1'b1;
            mem_rdata  = beat_data(caddr, beat);
            mem_rlast  = (beat == BURST - 1) || ((nreq - 1) == r_bad && beat == 30);
          end else begin
            mem_rvalid = 1'b0; mem_rlast = 1'b0;
          end
        end else if (!act) begin
          mem_rvalid = 1'b0; mem_rlast = 1'b0;
        end
      end
    end
  end

  // Monitor: requests, forwarded beats, inter-burst idle, done pulses, invariants.
  initial begin
    int beats_in_job, idle_run;
    logic prev_arv, prev_hs;
    logic [31:0] prev_addr;
    beats_in_job = 0; idle_run = 1000; prev_arv = 1'b0; prev_hs = 1'b0; prev_addr = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        beats_in_job = 0; idle_run = 1000; prev_arv = 1'b0;
      end else begin
        if (mem_arvalid && mem_arready) obs_addr.push_back(mem_araddr);
        if (prev_arv && !prev_hs && (!mem_arvalid || mem_araddr !== prev_addr)) ar_unstable++;
        prev_arv = mem_arvalid; prev_hs = mem_arvalid && mem_arready; prev_addr = mem_araddr;
        if (rvalid) begin
          if (beats_in_job > 0 && beats_in_job % BURST == 0 && idle_run < GAP) gap_viol++;
          obs_beat.push_back(rdata);
          beats_in_job++;
          idle_run = 0;
        end else begin
          idle_run++;
        end
        if (done) done_cnt++;
        if (busy !== data_load) dl_viol++;
      end
    end
  end

  function automatic vec_t mk(input int nc, input logic [31:0] b, input logic [31:0] rp,
                              input logic [31:0] cp, input int ard, input int stall, input int bad,
                              input int poke, input int er, input int ci, input logic [31:0] ca,
                              input logic ee);
    vec_t v;
    v.nchan = nc; v.base = b; v.rp = rp; v.cp = cp; v.ard = ard; v.stall = stall; v.bad = bad;
    v.poke = poke; v.exp_reqs = er; v.chk_idx = ci; v.chk_addr = ca; v.exp_err = ee;
    return v;
  endfunction

  task automatic run_job(input vec_t v, input int id);
    logic [31:0] ea[$];
    int a0, b0, d0, g0, l0, u0, cyc, mism, nb;
    bit got;
    for (int c = 0; c < v.nchan; c++)
      for (int r = 0; r < ROWS; r++)
        ea.push_back(v.base + 32'(c) * v.cp + 32'(r) * v.rp);
    r_ard = v.ard; r_stall = v.stall; r_bad = v.bad; job_id++;
    @(posedge clk);
    #1;
    a0 = obs_addr.size(); b0 = obs_beat.size(); d0 = done_cnt;
    g0 = gap_viol; l0 = dl_viol; u0 = ar_unstable;
    start = 1'b1; base_addr = v.base; row_pitch = v.rp; chan_pitch = v.cp; nchan = 16'(v.nchan);
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    chk($sformatf("j%0d_err_cleared", id), err, 0);
    chk($sformatf("j%0d_data_load", id), data_load, 1);
    chk($sformatf("j%0d_busy", id), busy, 1);
    got = 0; cyc = 0;
    while (!got && cyc < 8000) begin
      @(negedge clk);
      cyc++;
      if (done) got = 1;
      if (v.poke != 0 && cyc == v.poke) begin
        start = 1'b1; base_addr = 32'hDEAD_0000; nchan = 16'd5;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    chk($sformatf("j%0d_done_seen", id), got, 1);
    repeat (12) @(negedge clk);
    chk($sformatf("j%0d_req_count", id), obs_addr.size() - a0, v.exp_reqs);
    mism = 0;
    for (int k = 0; k < ea.size(); k++)
      if (a0 + k < obs_addr.size() && obs_addr[a0 + k] !== ea[k]) mism++;
    chk($sformatf("j%0d_addr_mismatches", id), mism, 0);
    if (v.chk_idx >= 0)
      chk($sformatf("j%0d_addr_idx%0d", id, v.chk_idx),
          (a0 + v.chk_idx < obs_addr.size()) ? obs_addr[a0 + v.chk_idx] : 32'hFFFF_FFFF, v.chk_addr);
    nb = obs_beat.size() - b0;
    chk($sformatf("j%0d_beat_count", id), nb, v.exp_reqs * BURST);
    mism = 0;
    for (int k = 0; k < ea.size() * BURST; k++)
      if (b0 + k < obs_beat.size() && obs_beat[b0 + k] !== beat_data(ea[k / BURST], k % BURST)) mism++;
    chk($sformatf("j%0d_beat_mismatches", id), mism, 0);
    chk($sformatf("j%0d_done_pulses", id), done_cnt - d0, 1);
    chk($sformatf("j%0d_short_gaps", id), gap_viol - g0, 0);
    chk($sformatf("j%0d_dataload_vs_busy", id), dl_viol - l0, 0);
    chk($sformatf("j%0d_ar_unstable", id), ar_unstable - u0, 0);
    chk($sformatf("j%0d_err", id), err, v.exp_err);
  endtask

  task automatic reset_mid_burst();
    int b0, d0, cyc;
    r_ard = 0; r_stall = 20; r_bad = -1; job_id++;
    @(posedge clk);
    #1;
    b0 = obs_beat.size();
    start = 1'b1; base_addr = 32'h3000; row_pitch = 32'h80; chan_pitch = 32'h0; nchan = 16'd1;
    @(posedge clk);
    #1 start = 1'b0;
    cyc = 0;
    while (obs_beat.size() - b0 < 3 * BURST + 10 && cyc < 3000) begin
      @(negedge clk);
      cyc++;
    end
    chk("rst_reached_burst4", obs_beat.size() - b0 >= 3 * BURST + 10, 1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_arvalid", mem_arvalid, 0);
    chk("rst_araddr", mem_araddr, 0);
    chk("rst_rready", mem_rready, 0);
    chk("rst_data_load", data_load, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    d0 = done_cnt; b0 = obs_beat.size();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (30) @(negedge clk);
    chk("rst_no_done", done_cnt - d0, 0);
    chk("rst_no_late_beats", obs_beat.size() - b0, 0);
    chk("rst_idle_rready", mem_rready, 0);
    chk("rst_idle_busy", busy, 0);
  endtask

  task automatic nchan0_seq();
    int a0, d0;
    r_ard = 0; r_stall = 0; r_bad = -1; job_id++;
    @(posedge clk);
    #1;
    a0 = obs_addr.size(); d0 = done_cnt;
    start = 1'b1; nchan = 16'd0; base_addr = 32'h7000;
    @(posedge clk);
    #1 nchan = 16'd1;
    @(negedge clk);
    chk("n0_done_cycle1", done, 0);
    chk("n0_busy_cycle1", busy, 1);
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    chk("n0_done_cycle2", done, 1);
    chk("n0_busy_cycle2", busy, 0);
    chk("n0_data_load_cycle2", data_load, 0);
    repeat (20) @(negedge clk);
    chk("n0_no_requests", obs_addr.size() - a0, 0);
    chk("n0_done_once", done_cnt - d0, 1);
  endtask

  initial begin
    vec_t tbl[7];
    vec_t v;
    tbl[0] = mk(1, 32'h1000,      32'h80,  32'h4000, 0, 0,  -1, 0,   9,  8, 32'h1400, 1'b0);
    tbl[1] = mk(2, 32'h1000,      32'h80,  32'h4000, 0, 0,  -1, 40,  18, 9, 32'h5000, 1'b0);
    tbl[2] = mk(1, 32'h1000,      32'h80,  32'h4000, 5, 0,  -1, 0,   9,  8, 32'h1400, 1'b0);
    tbl[3] = mk(1, 32'h1000,      32'h80,  32'h4000, 0, 0,  3,  250, 9,  3, 32'h1180, 1'b1);
    tbl[4] = mk(1, 32'h2000,      32'h100, 32'h0,    0, 30, -1, 0,   9,  8, 32'h2800, 1'b0);
    tbl[5] = mk(0, 32'h1000,      32'h80,  32'h4000, 0, 0,  -1, 0,   0, -1, 32'h0,    1'b0);
    tbl[6] = mk(2, 32'hFFFF_FF00, 32'h40,  32'h200,  1, 10, -1, 0,   18, 9, 32'h0100, 1'b0);

    rst_n = 1'b1; start = 1'b0; base_addr = '0; row_pitch = '0; chan_pitch = '0; nchan = '0;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_arvalid", mem_arvalid, 0);
    chk("reset_rready", mem_rready, 0);
    chk("reset_data_load", data_load, 0);
    chk("reset_rvalid", rvalid, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_err", err, 0);
    chk("arlen", mem_arlen, BURST - 1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    for (int i = 0; i < 7; i++) run_job(tbl[i], i);
    reset_mid_burst();
    run_job(tbl[0], 7);
    nchan0_seq();

    for (int i = 0; i < 4; i++) begin
      v.nchan = int'($urandom_range(1, 2));
      v.base = $urandom; v.rp = $urandom & 32'h0000_FFF0; v.cp = $urandom;
      v.ard = int'($urandom_range(0, 3)); v.stall = int'($urandom_range(0, 40));
      if ($urandom_range(0, 1) == 1) v.bad = int'($urandom_range(0, v.nchan * ROWS - 1));
      else v.bad = -1;
      v.poke = 0; v.exp_reqs = v.nchan * ROWS; v.chk_idx = -1; v.chk_addr = '0;
      v.exp_err = (v.bad >= 0);
      run_job(v, 10 + i);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
